branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 91 +++++++++
 tb/tb_branch_resolve.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch compare/resolve unit: evaluates the branch condition, registers the
// outcome behind a valid/ready handshake and trains a 2-bit counter BHT.
module branch_resolve #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BHT_DEPTH = 16,
  localparam int unsigned IDX      = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic [IDX-1:0]   idx,
  input  logic             pred_in,
  input  logic [IDX-1:0]   look_idx,
  output logic             look_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Br,
  output logic             mispredict,
  output logic [15:0]      miss_cnt
);

  localparam logic [15:0] MISS_MAX = 16'hFFFF;

  logic [1:0] bht [BHT_DEPTH];
  logic       accept;
  logic       br_c;
  logic       op_ok_c;
  logic       mis_c;
  logic       a_neg;
  logic       a_zero;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign look_taken = bht[look_idx][1];

  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);
  assign mis_c  = br_c ^ pred_in;

  // Condition decode; zero-compares use the sign bit directly.
  always_comb begin
    br_c    = 1'b0;
    op_ok_c = 1'b1;
    case (Op)
      4'd1:    br_c = (A == B);
      4'd2:    br_c = (A != B);
      4'd3:    br_c = ($signed(A) >= $signed(B));
      4'd4:    br_c = !a_neg && !a_zero;
      4'd5:    br_c = a_neg || a_zero;
      4'd6:    br_c = a_neg;
      4'd7:    br_c = !a_neg;
      4'd8:    br_c = (A < B);
      4'd9:    br_c = (A >= B);
      default: op_ok_c = 1'b0;
    endcase
  end

  // Result register, mispredict counter and BHT training.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      Br         <= 1'b0;
      mispredict <= 1'b0;
      miss_cnt   <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept) begin
      out_valid  <= 1'b1;
      Br         <= br_c;
      mispredict <= mis_c;
      if (op_ok_c) begin
        if (mis_c && (miss_cnt != MISS_MAX)) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
        if (br_c && (bht[idx] != 2'b11)) begin
          bht[idx] <= bht[idx] + 2'd1;
        end else if (!br_c && (bht[idx] != 2'b00)) begin
          bht[idx] <= bht[idx] - 2'd1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed corner cases plus random traffic
// checked against a plain-arithmetic reference model.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic [3:0]  idx;
  logic        pred_in;
  logic [3:0]  look_idx;
  logic        look_taken;
  logic        out_valid;
  logic        out_ready;
  logic        Br;
  logic        mispredict;
  logic [15:0] miss_cnt;

  branch_resolve #(.WIDTH(32), .BHT_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .idx(idx), .pred_in(pred_in),
    .look_idx(look_idx), .look_taken(look_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .Br(Br), .mispredict(mispredict), .miss_cnt(miss_cnt)
  );

  typedef struct {
    bit br;
    bit mis;
    int miss;
  } exp_t;

  exp_t q[$];
  int   m_bht[16];
  int   m_miss;
  bit   m_ov;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit ref_br(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    longint ua;
    longint ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      4'd1: return ua == ub;
      4'd2: return ua != ub;
      4'd3: return sa >= sb;
      4'd4: return sa > 0;
      4'd5: return sa <= 0;
      4'd6: return sa < 0;
      4'd7: return sa >= 0;
      4'd8: return ua < ub;
      4'd9: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus; checks visible state against the model, then
  // advances the model as the coming edge will.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] ix, input bit pred,
                      input bit ordy, input logic [3:0] lidx);
    bit   acc;
    bit   br;
    bit   mis;
    exp_t e;
    @(negedge clk);
    #1;
    reset = 1'b0; in_valid = iv; A = a; B = b; Op = op; idx = ix;
    pred_in = pred; out_ready = ordy; look_idx = lidx;
    #1;
    chk("in_ready", longint'(in_ready), longint'(!m_ov || ordy));
    chk("out_valid", longint'(out_valid), longint'(m_ov));
    chk("miss_cnt", longint'(miss_cnt), longint'(m_miss));
    chk("look_taken", longint'(look_taken), longint'(m_bht[lidx] >= 2));
    acc = iv && (!m_ov || ordy);
    if (acc) begin
      br  = ref_br(op, a, b);
      mis = (br != pred);
      if (op >= 4'd1 && op <= 4'd9) begin
        if (br) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
        else    m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
        if (mis && m_miss < 65535) m_miss++;
      end
      e.br = br; e.mis = mis; e.miss = m_miss;
      q.push_back(e);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = $urandom; B = $urandom; Op = 4'd1; idx = 4'($urandom); pred_in = 1'b1;
    q.delete();
    m_ov = 1'b0;
    m_miss = 0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Monitor: a presented result must match the oldest outstanding expectation
  // and stay there until it is taken.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("Br", longint'(Br), longint'(q[0].br));
          chk("mispredict", longint'(mispredict), longint'(q[0].mis));
          chk("miss_cnt_out", longint'(miss_cnt), longint'(q[0].miss));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          budget;
    checks = 0; failures = 0;
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; Op = '0; idx = '0;
    pred_in = 1'b0; out_ready = 1'b0; look_idx = '0;
    do_reset();
    do_reset();

    // First accept after reset, then a result-visible cycle looking at idx 3
    step(1'b1, 32'd5, 32'd5, 4'd1, 4'd3, 1'b0, 1'b1, 4'($urandom));
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);

    // Signed versus unsigned compares on all-ones against one
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd3, 4'd1, 1'b0, 1'b1, 4'd1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd9, 4'd1, 1'b0, 1'b1, 4'd1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd6, 4'd1, 1'b0, 1'b1, 4'd1);
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd8, 4'd1, 1'b0, 1'b1, 4'd1);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1);

    // Backpressure: stall five cycles, then drain and accept together
    step(1'b1, 32'd7, 32'd9, 4'd8, 4'd2, 1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'd3, 32'd3, 4'd2, 4'd2, 1'b1, 1'b0, 4'd2);
    step(1'b1, 32'd3, 32'd3, 4'd2, 4'd2, 1'b1, 1'b1, 4'd2);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2);

    // Counter saturation on idx 0, then an undefined opcode
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'd4, 32'd4, 4'd1, 4'd0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'd4, 32'd4, 4'd2, 4'd0, 1'b1, 1'b1, 4'd0);
    step(1'b1, 32'd4, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0);

    // Read-before-write on idx 7
    step(1'b1, 32'd1, 32'd1, 4'd1, 4'd7, 1'b0, 1'b1, 4'd7);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7);

    // Reset while a result is stalled
    step(1'b1, 32'd1, 32'd2, 4'd2, 4'd5, 1'b0, 1'b1, 4'd5);
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
    do_reset();
    for (int i = 0; i < 16; i++)
      step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'(i));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
        2:       begin ra = 32'($urandom_range(0, 4)) - 32'd2; rb = $urandom; end
        default: rb = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), ra, rb, 4'($urandom_range(0, 11)),
           4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    // Drain whatever is outstanding within a bounded number of cycles
    budget = 0;
    while ((q.size() != 0) && (budget < 10)) begin
      step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0);
      budget++;
    end
    step(1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0);
    chk("drain_queue_empty", longint'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
